// File: rtl/key_debounce.sv
`default_nettype none
// key_debounce: per-key bounce filter for 16 synchronized keys, plus a press queue
// that emits one single-cycle key_in/key_val event per debounced press, lowest index first.
module key_debounce #(
  parameter int STABLE_CYCLES = 1000,
  parameter int CNT_WIDTH     = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] keys_in,
  output logic [15:0] keys_out,
  output logic        key_in,
  output logic [3:0]  key_val,
  output logic        busy
);

  localparam int                   NUM_KEYS = 16;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] cnt [NUM_KEYS];
  logic [15:0]          pending;
  logic [15:0]          level_next;
  logic [15:0]          rise;
  logic [15:0]          lowest_mask;
  logic [15:0]          pending_next;
  logic [3:0]           lowest_idx;

  always_comb begin
    level_next = keys_out;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (keys_in[i] != keys_out[i] && cnt[i] == CNT_LAST) begin
        level_next[i] = keys_in[i];
      end
    end
  end

  assign rise        = level_next & ~keys_out;
  // Two's-complement trick isolates the lowest pending bit, the one emitted this edge.
  assign lowest_mask = pending & (~pending + 16'd1);

  always_comb begin
    lowest_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        lowest_idx = 4'(i);
      end
    end
  end

  // A press landing on the bit being emitted is OR-ed back in, so it is emitted again later.
  assign pending_next = (pending & ~lowest_mask) | rise;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      keys_out <= '0;
      pending  <= '0;
      key_in   <= 1'b0;
      key_val  <= '0;
      busy     <= 1'b0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      keys_out <= level_next;
      pending  <= pending_next;
      busy     <= |pending_next;
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (keys_in[i] == keys_out[i] || cnt[i] == CNT_LAST) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
      if (|pending) begin
        key_in  <= 1'b1;
        key_val <= lowest_idx;
      end else begin
        key_in  <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_key_debounce.sv
`default_nettype none
// tb_key_debounce: table vectors, hand-written corner sequences and randomized keys
// checked against a rule-level model, on a STABLE_CYCLES=4 and a STABLE_CYCLES=1 instance.
module tb_key_debounce;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] keys4 = '0;
  logic [15:0] keys1 = '0;
  logic [15:0] ko4, ko1;
  logic        ki4, ki1, b4, b1;
  logic [3:0]  kv4, kv1;

  always #5 clock = ~clock;

  key_debounce #(.STABLE_CYCLES(4), .CNT_WIDTH(16)) dut4 (
    .clock(clock), .reset(reset), .keys_in(keys4), .keys_out(ko4),
    .key_in(ki4), .key_val(kv4), .busy(b4)
  );

  key_debounce #(.STABLE_CYCLES(1), .CNT_WIDTH(16)) dut1 (
    .clock(clock), .reset(reset), .keys_in(keys1), .keys_out(ko1),
    .key_in(ki1), .key_val(kv1), .busy(b1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Rule-level model: each key tracks how many consecutive samples disagreed with its level.
  int          m_stable [2] = '{4, 1};
  logic [15:0] m_level  [2];
  int          m_run    [2][16];
  logic [15:0] m_pend   [2];
  logic        m_kin    [2];
  logic [3:0]  m_kval   [2];

  int ev4[$];
  int ev1[$];

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_level[d] = '0;
      m_pend[d]  = '0;
      m_kin[d]   = 1'b0;
      m_kval[d]  = '0;
      for (int i = 0; i < 16; i++) m_run[d][i] = 0;
    end
  endfunction

  function automatic void model_step(int d, logic [15:0] k);
    logic [15:0] old_level;
    int          first;
    old_level = m_level[d];
    for (int i = 0; i < 16; i++) begin
      if (k[i] == m_level[d][i]) begin
        m_run[d][i] = 0;
      end else if (m_run[d][i] + 1 >= m_stable[d]) begin
        m_level[d][i] = k[i];
        m_run[d][i]   = 0;
      end else begin
        m_run[d][i] = m_run[d][i] + 1;
      end
    end
    first = -1;
    for (int i = 0; i < 16; i++) begin
      if (m_pend[d][i] && first < 0) first = i;
    end
    if (first >= 0) begin
      m_kin[d]         = 1'b1;
      m_kval[d]        = 4'(first);
      m_pend[d][first] = 1'b0;
    end else begin
      m_kin[d] = 1'b0;
    end
    m_pend[d] = m_pend[d] | (m_level[d] & ~old_level);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("d4.keys_out", 32'(ko4), 32'(m_level[0]));
    check("d4.key_in",   32'(ki4), 32'(m_kin[0]));
    check("d4.key_val",  32'(kv4), 32'(m_kval[0]));
    check("d4.busy",     32'(b4),  32'(m_pend[0] != 16'd0));
    check("d1.keys_out", 32'(ko1), 32'(m_level[1]));
    check("d1.key_in",   32'(ki1), 32'(m_kin[1]));
    check("d1.key_val",  32'(kv1), 32'(m_kval[1]));
    check("d1.busy",     32'(b1),  32'(m_pend[1] != 16'd0));
  endtask

  // Inputs change at the falling edge; outputs are read at the next falling edge.
  task automatic step(input logic [15:0] k4, input logic [15:0] k1);
    keys4 = k4;
    keys1 = k1;
    @(posedge clock);
    model_step(0, k4);
    model_step(1, k1);
    @(negedge clock);
    if (ki4) ev4.push_back(int'(kv4));
    if (ki1) ev1.push_back(int'(kv1));
    compare_model();
  endtask

  task automatic check_events(input string name, input int got[$], input int exp[$]);
    check({name, ".count"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (i < got.size()) check({name, ".val"}, 32'(got[i]), 32'(exp[i]));
    end
  endtask

  typedef struct {
    logic [15:0] keys;
    logic [15:0] exp_out;
    logic        exp_kin;
    logic [3:0]  exp_kval;
    logic        exp_busy;
  } vec_t;

  vec_t tbl[14];

  initial begin
    // Single press of key 2, held 10 cycles, then released.
    tbl[0]  = '{16'h0004, 16'h0000, 1'b0, 4'd0, 1'b0};
    tbl[1]  = '{16'h0004, 16'h0000, 1'b0, 4'd0, 1'b0};
    tbl[2]  = '{16'h0004, 16'h0000, 1'b0, 4'd0, 1'b0};
    tbl[3]  = '{16'h0004, 16'h0004, 1'b0, 4'd0, 1'b1};
    tbl[4]  = '{16'h0004, 16'h0004, 1'b1, 4'd2, 1'b0};
    tbl[5]  = '{16'h0004, 16'h0004, 1'b0, 4'd2, 1'b0};
    tbl[6]  = '{16'h0004, 16'h0004, 1'b0, 4'd2, 1'b0};
    tbl[7]  = '{16'h0004, 16'h0004, 1'b0, 4'd2, 1'b0};
    tbl[8]  = '{16'h0004, 16'h0004, 1'b0, 4'd2, 1'b0};
    tbl[9]  = '{16'h0004, 16'h0004, 1'b0, 4'd2, 1'b0};
    tbl[10] = '{16'h0000, 16'h0004, 1'b0, 4'd2, 1'b0};
    tbl[11] = '{16'h0000, 16'h0004, 1'b0, 4'd2, 1'b0};
    tbl[12] = '{16'h0000, 16'h0004, 1'b0, 4'd2, 1'b0};
    tbl[13] = '{16'h0000, 16'h0000, 1'b0, 4'd2, 1'b0};

    model_reset();
    repeat (2) @(negedge clock);
    check("reset.keys_out", 32'(ko4), 32'd0);
    check("reset.key_in",   32'(ki4), 32'd0);
    check("reset.key_val",  32'(kv4), 32'd0);
    check("reset.busy",     32'(b4),  32'd0);
    reset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].keys, 16'h0000);
      check("tbl.keys_out", 32'(ko4), 32'(tbl[i].exp_out));
      check("tbl.key_in",   32'(ki4), 32'(tbl[i].exp_kin));
      check("tbl.key_val",  32'(kv4), 32'(tbl[i].exp_kval));
      check("tbl.busy",     32'(b4),  32'(tbl[i].exp_busy));
    end

    // Bounce on key 5: only the final run of four 1s may change the level.
    begin
      logic [8:0] pattern;
      pattern = 9'b1_1110_1101;
      ev4.delete();
      for (int i = 0; i < 9; i++) begin
        step(pattern[i] ? 16'h0020 : 16'h0000, 16'h0000);
        check("bounce.level", 32'(ko4[5]), (i == 8) ? 32'd1 : 32'd0);
      end
      repeat (6) step(16'h0020, 16'h0000);
      check_events("bounce.events", ev4, '{5});
      repeat (6) step(16'h0000, 16'h0000);
    end

    // Simultaneous presses of keys 0, 8, 15.
    ev4.delete();
    for (int c = 1; c <= 8; c++) begin
      step(16'h8101, 16'h0000);
      if (c == 3) check("simul.before", 32'(ko4), 32'h0000);
      if (c == 4) check("simul.level", 32'(ko4), 32'h8101);
      if (c >= 4) check("simul.busy", 32'(b4), (c <= 6) ? 32'd1 : 32'd0);
    end
    check_events("simul.events", ev4, '{0, 8, 15});
    repeat (6) step(16'h0000, 16'h0000);

    // Asynchronous reset in the middle of the burst, keys still held.
    repeat (5) step(16'h8101, 16'h0000);
    check("areset.pre_kin", 32'(ki4), 32'd1);
    reset = 1'b0;
    #1;
    check("areset.keys_out", 32'(ko4), 32'd0);
    check("areset.key_in",   32'(ki4), 32'd0);
    check("areset.key_val",  32'(kv4), 32'd0);
    check("areset.busy",     32'(b4),  32'd0);
    model_reset();
    @(negedge clock);
    check("areset.held", 32'({ko4, ki4, kv4, b4}), 32'd0);
    reset = 1'b1;
    ev4.delete();
    repeat (8) step(16'h8101, 16'h0000);
    check_events("areset.events", ev4, '{0, 8, 15});
    repeat (6) step(16'h0000, 16'h0000);

    // STABLE_CYCLES=1: key 1 released while still queued is emitted once.
    ev1.delete();
    step(16'h0000, 16'h0003);
    step(16'h0000, 16'h0001);
    step(16'h0000, 16'h0001);
    step(16'h0000, 16'h0001);
    check_events("release_queued.events", ev1, '{0, 1});
    check("release_queued.level", 32'(ko1), 32'h0001);
    repeat (2) step(16'h0000, 16'h0000);

    // Key 1 re-pressed on the edge that emits it: a second, genuine press event.
    ev1.delete();
    step(16'h0000, 16'h0003);
    step(16'h0000, 16'h0001);
    step(16'h0000, 16'h0003);
    step(16'h0000, 16'h0003);
    step(16'h0000, 16'h0003);
    check_events("repress.events", ev1, '{0, 1, 1});
    check("repress.busy", 32'(b1), 32'd0);
    repeat (2) step(16'h0000, 16'h0000);

    // Randomized key activity, mostly stable with occasional flips and glitches.
    begin
      logic [15:0] r4, r1;
      r4 = '0;
      r1 = '0;
      for (int n = 0; n < 3000; n++) begin
        int sel;
        sel = int'($urandom_range(0, 15));
        if (sel < 3) r4[$urandom_range(0, 15)] ^= 1'b1;
        if (sel == 4) r4 = 16'($urandom);
        if (sel < 5) r1[$urandom_range(0, 15)] ^= 1'b1;
        if (sel == 6) r1 = 16'($urandom);
        step(r4, r1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
